// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM: Moore state machine driving datapath enables.
// Define MULTI_CYCLE_CTRL_JUMP_EN to support the J instruction; otherwise opcode 000010 traps.
module multi_cycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic        illegal,
   output logic        halted,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic [3:0]  state,
   output logic [31:0] instr_cnt
);

   localparam logic [3:0] FETCH  = 4'd0;
   localparam logic [3:0] DECODE = 4'd1;
   localparam logic [3:0] MEMADR = 4'd2;
   localparam logic [3:0] MEMRD  = 4'd3;
   localparam logic [3:0] MEMWB  = 4'd4;
   localparam logic [3:0] MEMWR  = 4'd5;
   localparam logic [3:0] EXEC   = 4'd6;
   localparam logic [3:0] RWB    = 4'd7;
   localparam logic [3:0] BRANCH = 4'd8;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
   localparam logic [3:0] JUMP   = 4'd9;
   localparam logic [5:0] OP_J   = 6'b000010;
`endif
   localparam logic [3:0] TRAP   = 4'd15;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   logic [3:0]  state_reg, state_next;
   logic [31:0] instr_cnt_reg;
   logic        retire;

   // The branch decision is taken in the datapath (pc_write_cond & zero); zero is only observed here.
   logic unused_zero;
   assign unused_zero = zero;

   always_comb begin
      state_next = state_reg;
      retire     = 1'b0;
      case (state_reg)
         FETCH:  if (mem_ready) state_next = DECODE;
         DECODE: begin
            case (opcode)
               OP_RTYPE:     state_next = EXEC;
               OP_LW, OP_SW: state_next = MEMADR;
               OP_BEQ:       state_next = BRANCH;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
               OP_J:         state_next = JUMP;
`endif
               default:      state_next = TRAP;
            endcase
         end
         MEMADR: begin
            if (opcode == OP_LW)      state_next = MEMRD;
            else if (opcode == OP_SW) state_next = MEMWR;
            else                      state_next = TRAP;
         end
         MEMRD:  if (mem_ready) state_next = MEMWB;
         MEMWB: begin
            state_next = FETCH;
            retire     = 1'b1;
         end
         MEMWR: begin
            if (mem_ready) begin
               state_next = FETCH;
               retire     = 1'b1;
            end
         end
         EXEC:   state_next = RWB;
         RWB, BRANCH: begin
            state_next = FETCH;
            retire     = 1'b1;
         end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
         JUMP: begin
            state_next = FETCH;
            retire     = 1'b1;
         end
`endif
         TRAP:    state_next = TRAP;
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= FETCH;
         instr_cnt_reg <= 32'd0;
      end else begin
         state_reg <= state_next;
         if (retire) instr_cnt_reg <= instr_cnt_reg + 32'd1;
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      illegal       = 1'b0;
      halted        = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      case (state_reg)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: alu_src_b = 2'b11;
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_source     = 2'b01;
            pc_write_cond = 1'b1;
         end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
`endif
         TRAP: begin
            illegal = 1'b1;
            halted  = 1'b1;
         end
         default: ;
      endcase
      // Architectural write enables must not fire while reset is held, whatever the state.
      if (!rst_n) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
      end
   end

   assign state     = state_reg;
   assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl; honours MULTI_CYCLE_CTRL_JUMP_EN for the J test.
module tb_multi_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal, halted;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic [31:0] instr_cnt;
   logic [17:0] ctl;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   multi_cycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .illegal(illegal), .halted(halted),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .state(state), .instr_cnt(instr_cnt)
   );

   // {pw,pwc,iod,mr,mw,irw,m2r,rdst,rw,asa,ill,hlt, alu_src_b, alu_op, pc_source}
   assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, illegal, halted,
                 alu_src_b, alu_op, pc_source};

   localparam logic [17:0] C_FETCH_R = 18'b100101000000_010000;
   localparam logic [17:0] C_FETCH_W = 18'b000100000000_010000;
   localparam logic [17:0] C_RST     = 18'b000000000000_010000;
   localparam logic [17:0] C_DEC     = 18'b000000000000_110000;
   localparam logic [17:0] C_MADR    = 18'b000000000100_100000;
   localparam logic [17:0] C_MRD     = 18'b001100000000_000000;
   localparam logic [17:0] C_MWB     = 18'b000000101000_000000;
   localparam logic [17:0] C_MWR     = 18'b001010000000_000000;
   localparam logic [17:0] C_EXEC    = 18'b000000000100_001000;
   localparam logic [17:0] C_RWB     = 18'b000000011000_000000;
   localparam logic [17:0] C_BR      = 18'b010000000100_000101;
   localparam logic [17:0] C_TRAP    = 18'b000000000011_000000;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
   localparam logic [17:0] C_JMP     = 18'b100000000000_000010;
`endif

   task automatic test_reset;
      rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0;
      @(posedge clk); #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++; if (instr_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", instr_cnt); end
      checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_forced_ctl: got %b want %b", ctl, C_RST); end
      rst_n = 1'b1; #1;
      checks++; if (ctl !== C_FETCH_R) begin errors++; $display("FAIL reset_release_ctl: got %b want %b", ctl, C_FETCH_R); end
      exp_cnt = 0;
   endtask

   task automatic test_rtype;
      logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
      logic [17:0] ec [4] = '{C_FETCH_R, C_DEC, C_EXEC, C_RWB};
      opcode = 6'b000000; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, es[i]); end
         checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL rtype_ctl[%0d]: got %b want %b", i, ctl, ec[i]); end
         checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL rtype_cnt[%0d]: got %0d want %0d", i, instr_cnt, exp_cnt); end
         @(posedge clk); #1;
      end
      exp_cnt++;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL rtype_end_state: got %0d want 0", state); end
      checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL rtype_end_cnt: got %0d want %0d", instr_cnt, exp_cnt); end
   endtask

   task automatic test_lw_stall;
      logic [3:0]  es  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
      logic [17:0] ec  [8] = '{C_FETCH_R, C_DEC, C_MADR, C_MRD, C_MRD, C_MRD, C_MRD, C_MWB};
      logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      opcode = 6'b100011;
      for (int i = 0; i < 8; i++) begin
         mem_ready = rdy[i]; #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, es[i]); end
         checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL lw_ctl[%0d]: got %b want %b", i, ctl, ec[i]); end
         checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL lw_cnt[%0d]: got %0d want %0d", i, instr_cnt, exp_cnt); end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      exp_cnt++;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_end_state: got %0d want 0", state); end
      checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL lw_end_cnt: got %0d want %0d", instr_cnt, exp_cnt); end
   endtask

   task automatic test_sw;
      logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
      logic [17:0] ec [4] = '{C_FETCH_R, C_DEC, C_MADR, C_MWR};
      opcode = 6'b101011; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, es[i]); end
         checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL sw_ctl[%0d]: got %b want %b", i, ctl, ec[i]); end
         @(posedge clk); #1;
      end
      exp_cnt++;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_end_state: got %0d want 0", state); end
      checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL sw_end_cnt: got %0d want %0d", instr_cnt, exp_cnt); end
   endtask

   task automatic test_beq;
      logic [3:0]  es  [4] = '{4'd0, 4'd0, 4'd1, 4'd8};
      logic [17:0] ec  [4] = '{C_FETCH_W, C_FETCH_R, C_DEC, C_BR};
      logic        rdy [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      opcode = 6'b000100; zero = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_ready = rdy[i]; #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, state, es[i]); end
         checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL beq_ctl[%0d]: got %b want %b", i, ctl, ec[i]); end
         @(posedge clk); #1;
      end
      zero = 1'b0;
      exp_cnt++;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL beq_end_state: got %0d want 0", state); end
      checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL beq_end_cnt: got %0d want %0d", instr_cnt, exp_cnt); end
   endtask

   task automatic test_memwr_reset;
      logic [3:0]  es  [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
      logic [17:0] ec  [5] = '{C_FETCH_R, C_DEC, C_MADR, C_MWR, C_MWR};
      logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      opcode = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = rdy[i]; #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL swstall_state[%0d]: got %0d want %0d", i, state, es[i]); end
         checks++; if (ctl !== ec[i]) begin errors++; $display("FAIL swstall_ctl[%0d]: got %b want %b", i, ctl, ec[i]); end
         @(posedge clk); #1;
      end
      checks++; if (state !== 4'd5) begin errors++; $display("FAIL swstall_held: got %0d want 5", state); end
      checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL swstall_cnt: got %0d want %0d", instr_cnt, exp_cnt); end
      rst_n = 1'b0; #1;
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL swstall_rst_mem_write: got %b want 0", mem_write); end
      @(posedge clk); #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL swstall_rst_state: got %0d want 0", state); end
      checks++; if (instr_cnt !== 32'd0) begin errors++; $display("FAIL swstall_rst_cnt: got %0d want 0", instr_cnt); end
      rst_n = 1'b1; mem_ready = 1'b1; exp_cnt = 0; #1;
   endtask

   task automatic test_jump;
      opcode = 6'b000010; mem_ready = 1'b1; #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL j_state0: got %0d want 0", state); end
      @(posedge clk); #1;
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL j_state1: got %0d want 1", state); end
      @(posedge clk); #1;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
      checks++; if (state !== 4'd9) begin errors++; $display("FAIL j_state2: got %0d want 9", state); end
      checks++; if (ctl !== C_JMP) begin errors++; $display("FAIL j_ctl: got %b want %b", ctl, C_JMP); end
      @(posedge clk); #1;
      exp_cnt++;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL j_end_state: got %0d want 0", state); end
      checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL j_end_cnt: got %0d want %0d", instr_cnt, exp_cnt); end
`else
      checks++; if (state !== 4'd15) begin errors++; $display("FAIL j_trap_state: got %0d want 15", state); end
      checks++; if (ctl !== C_TRAP) begin errors++; $display("FAIL j_trap_ctl: got %b want %b", ctl, C_TRAP); end
      test_reset();
`endif
   endtask

   task automatic test_trap;
      opcode = 6'b111111; mem_ready = 1'b1; #1;
      @(posedge clk); #1;
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL trap_decode: got %0d want 1", state); end
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         mem_ready = i[0]; #1;
         checks++; if (state !== 4'd15) begin errors++; $display("FAIL trap_state[%0d]: got %0d want 15", i, state); end
         checks++; if (ctl !== C_TRAP) begin errors++; $display("FAIL trap_ctl[%0d]: got %b want %b", i, ctl, C_TRAP); end
         checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL trap_cnt[%0d]: got %0d want %0d", i, instr_cnt, exp_cnt); end
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1'b1; #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL trap_rst_state: got %0d want 0", state); end
      checks++; if (instr_cnt !== 32'd0) begin errors++; $display("FAIL trap_rst_cnt: got %0d want 0", instr_cnt); end
      checks++; if (ctl !== C_FETCH_R) begin errors++; $display("FAIL trap_rst_ctl: got %b want %b", ctl, C_FETCH_R); end
      exp_cnt = 0;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_stall();
      test_sw();
      test_beq();
      test_memwr_reset();
      test_rtype();
      test_jump();
      test_trap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
